// File: rtl/adc_logger_pkg.sv
// Shared FSM encoding, CSR bit positions and width helper for the ADC sample logger.
package adc_logger_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int RUN_BIT  = 0;
  localparam int MODE_BIT = 1;

  // Accumulator must hold 2^avg_log2 full-scale samples without wrapping.
  function automatic int acc_w(input int data_w, input int avg_log2);
    return data_w + avg_log2;
  endfunction

endpackage

// File: rtl/adc_sample_logger_ch_averager.sv
// One logical channel: block averager, alarm hysteresis and, with TEMP_MINMAX_EN,
// running min/max of the produced averages.
module ch_averager
  import adc_logger_pkg::*;
#(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              vld_p0,
  input  logic [DATA_W-1:0] smp_data,
  input  logic [DATA_W-1:0] thresh_hi,
  input  logic [DATA_W-1:0] thresh_lo,
`ifdef TEMP_MINMAX_EN
  output logic [DATA_W-1:0] min_avg,
  output logic [DATA_W-1:0] max_avg,
`endif
  output logic [DATA_W-1:0] avg,
  output logic              avg_valid,
  output logic              alarm
);

  localparam int ACC_W = acc_w(DATA_W, AVG_LOG2);
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]  acc_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic [ACC_W-1:0]  sum_p0;
  logic [DATA_W-1:0] avg_new;
  logic              close_p0;
  logic              vld_p1;

  function automatic logic [DATA_W-1:0] block_avg(input logic [ACC_W-1:0] s);
    return s[ACC_W-1:AVG_LOG2];
  endfunction

  assign sum_p0   = acc_p0 + ACC_W'(smp_data);
  assign avg_new  = block_avg(sum_p0);
  assign close_p0 = vld_p0 && !clear && (cnt_p0 == CNT_LAST);

  // Stage p0 -> p1: accumulate; the last sample of a block lands straight in avg.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_p0    <= '0;
      cnt_p0    <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= close_p0;
      if (clear) begin
        acc_p0 <= '0;
        cnt_p0 <= '0;
      end else if (close_p0) begin
        avg       <= avg_new;
        avg_valid <= 1'b1;
        acc_p0    <= '0;
        cnt_p0    <= '0;
      end else if (vld_p0) begin
        acc_p0 <= sum_p0;
        cnt_p0 <= cnt_p0 + 1'b1;
      end
    end
  end

  // Stage p1: hysteresis against the thresholds present at this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm <= 1'b0;
    end else if (vld_p1) begin
      if (avg > thresh_hi) begin
        alarm <= 1'b1;
      end else if (avg < thresh_lo) begin
        alarm <= 1'b0;
      end
    end
  end

`ifdef TEMP_MINMAX_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_avg <= '0;
      max_avg <= '0;
    end else if (close_p0) begin
      if (!avg_valid || avg_new < min_avg) min_avg <= avg_new;
      if (!avg_valid || avg_new > max_avg) max_avg <= avg_new;
    end
  end
`endif

endmodule

// File: rtl/adc_sample_logger.sv
// ADC sequencer control, channel decode and registered read port over NUM_CH averagers.
// Optional feature macro: TEMP_MINMAX_EN (per-channel min/max of averages on rd_min/rd_max).
module adc_sample_logger
  import adc_logger_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 12,
  parameter int CH_W      = 5,
  parameter int CH_BASE   = 0,
  parameter int AVG_LOG2  = 3,
  parameter int CONT_MODE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  output logic                      csr_write,
  output logic [31:0]               csr_writedata,
  input  logic                      s_valid,
  input  logic [CH_W-1:0]           s_channel,
  input  logic [DATA_W-1:0]         s_data,
  input  logic [DATA_W-1:0]         thresh_hi,
  input  logic [DATA_W-1:0]         thresh_lo,
  input  logic                      rd_req,
  input  logic [$clog2(NUM_CH)-1:0] rd_ch,
  output logic                      rd_ack,
  output logic [DATA_W-1:0]         rd_data,
  output logic [DATA_W-1:0]         rd_min,
  output logic [DATA_W-1:0]         rd_max,
  output logic [NUM_CH-1:0]         avg_valid,
  output logic [NUM_CH-1:0]         alarm,
  output logic                      drop_pulse
);

  localparam int CHI_W = $clog2(NUM_CH);
  localparam int RD_N  = 1 << CHI_W;

  state_t            state, state_nxt;
  logic              running;
  logic [31:0]       ch_off;
  logic              in_range;
  logic [CHI_W-1:0]  idx;
  logic [NUM_CH-1:0] vld_p0;
  logic [DATA_W-1:0] avg_arr [RD_N];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     if (!enable) state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  assign running   = (state == RUN);
  assign csr_write = (state == START) || (state == STOP);

  always_comb begin
    csr_writedata = '0;
    if (state == START) begin
      csr_writedata[RUN_BIT]  = 1'b1;
      csr_writedata[MODE_BIT] = (CONT_MODE != 0);
    end
  end

  // Channels below CH_BASE wrap to a huge offset, so one compare covers both ends.
  assign ch_off   = 32'(s_channel) - 32'(CH_BASE);
  assign in_range = (ch_off < 32'(NUM_CH));
  assign idx      = ch_off[CHI_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_pulse <= 1'b0;
    else      drop_pulse <= s_valid && !(running && in_range);
  end

`ifdef TEMP_MINMAX_EN
  logic [DATA_W-1:0] min_arr [RD_N];
  logic [DATA_W-1:0] max_arr [RD_N];
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign vld_p0[i] = running && s_valid && in_range && (idx == CHI_W'(i));

    ch_averager #(
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
      .clk       (clk),
      .rst       (rst),
      .clear     (state == STOP),
      .vld_p0    (vld_p0[i]),
      .smp_data  (s_data),
      .thresh_hi (thresh_hi),
      .thresh_lo (thresh_lo),
`ifdef TEMP_MINMAX_EN
      .min_avg   (min_arr[i]),
      .max_avg   (max_arr[i]),
`endif
      .avg       (avg_arr[i]),
      .avg_valid (avg_valid[i]),
      .alarm     (alarm[i])
    );
  end

  // Unpopulated read addresses return zero.
  for (genvar i = NUM_CH; i < RD_N; i++) begin : g_pad
    assign avg_arr[i] = '0;
`ifdef TEMP_MINMAX_EN
    assign min_arr[i] = '0;
    assign max_arr[i] = '0;
`endif
  end

  // Read stage p1: registered mux, value held until the next request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_ack <= rd_req;
      if (rd_req) rd_data <= avg_arr[rd_ch];
    end
  end

`ifdef TEMP_MINMAX_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_min <= '0;
      rd_max <= '0;
    end else if (rd_req) begin
      rd_min <= min_arr[rd_ch];
      rd_max <= max_arr[rd_ch];
    end
  end
`else
  assign rd_min = '0;
  assign rd_max = '1;
`endif

endmodule

// File: doc/adc_sample_logger.md
Name: adc_sample_logger

Overview:
Parametrised successor to the single-sample ADC-to-RAM capture path. Drives the ADC sequencer CSR start/stop and accepts the ADC response stream. Accumulates block averages of 2^AVG_LOG2 samples for NUM_CH channels and raises a per-channel over-temperature alarm with hysteresis. Exposes a registered read port for any channel's latest average. Sits between the ADC IP and display/alarm logic.

Parameters:
NUM_CH, 4, number of logical channels logged
DATA_W, 12, ADC sample width
CH_W, 5, width of ADC response channel field
CH_BASE, 0, ADC channel number mapped to logical channel 0
AVG_LOG2, 3, log2 of samples per average (8)
CONT_MODE, 1, 1 = continuous ADC mode, 0 = single-shot; sets CSR bit 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
enable  in  1  level; 1 = run ADC, 0 = stop
csr_write  out  1  sequencer CSR write strobe
csr_writedata  out  32  sequencer CSR write data
s_valid  in  1  ADC response valid
s_channel  in  CH_W  ADC response channel
s_data  in  DATA_W  ADC response data
thresh_hi  in  DATA_W  alarm set threshold
thresh_lo  in  DATA_W  alarm clear threshold
rd_req  in  1  read request pulse
rd_ch  in  $clog2(NUM_CH)  channel to read
rd_ack  out  1  read data valid, one cycle
rd_data  out  DATA_W  latest average of rd_ch
rd_min  out  DATA_W  min average (optional feature)
rd_max  out  DATA_W  max average (optional feature)
avg_valid  out  NUM_CH  channel has produced at least one average
alarm  out  NUM_CH  per-channel alarm
drop_pulse  out  1  one-cycle pulse on a discarded sample

Behaviour:
- Reset (rst=0, async): all outputs 0; accumulators and counters 0; FSM IDLE.
- FSM IDLE -> START when enable=1. START: csr_write=1 for one cycle, csr_writedata={30'b0, CONT_MODE, 1'b1}; -> RUN.
- RUN -> STOP when enable=0. STOP: csr_write=1 for one cycle, csr_writedata=0; all partial accumulators and sample counters cleared; -> IDLE. avg/alarm/min/max registers retained.
- Samples accepted only in RUN with s_valid=1. idx = s_channel - CH_BASE.
- Drop rule: idx outside 0..NUM_CH-1, or s_valid=1 outside RUN -> sample discarded; drop_pulse=1 on the next cycle.
- Accumulator width DATA_W+AVG_LOG2, never overflows.
- Per accepted sample: acc += s_data; cnt += 1.
- On the 2^AVG_LOG2-th sample: avg <= (acc + s_data) >> AVG_LOG2 (truncating); acc, cnt <= 0; avg_valid[idx] <= 1. All updates occur at the same edge as the sample.
- Alarm is registered one cycle after the avg update:
  - set if avg > thresh_hi;
  - clear if avg < thresh_lo;
  - otherwise hold.
  - Thresholds are sampled at evaluation time. thresh_lo > thresh_hi is undefined usage.
- Read port: rd_req sampled at edge N -> rd_ack=1 and rd_data valid during cycle N+1, for exactly one cycle. rd_data holds its value until the next read.
  - A read coinciding with an avg update of the same channel returns the pre-update value.
  - Back-to-back rd_req every cycle is supported.
  - rd_ch >= NUM_CH returns 0 with rd_ack=1.
- enable toggling during START/STOP takes effect after that state completes.

Optional Feature:
TEMP_MINMAX_EN
- Defined: per channel, track min and max of all produced averages since reset. The first average initialises both. rd_min/rd_max are returned alongside rd_data with the same timing.
- Undefined: no min/max storage; rd_min=0 and rd_max={DATA_W{1'b1}} constantly.

Decomposition:
- Package adc_logger_pkg:
  - FSM state enum (IDLE, START, RUN, STOP);
  - CSR bit positions (RUN_BIT=0, MODE_BIT=1);
  - ACC_W = DATA_W + AVG_LOG2 helper.
- Sub-module ch_averager: one per channel via generate. Contains the accumulator, counter, avg register, alarm hysteresis, and optional min/max. The top holds the FSM, channel decode/drop logic, and read mux.

Test Plan:
- Reset, enable=1 -> csr_write one cycle with writedata=32'h3 (CONT_MODE=1), FSM RUN. enable=0 -> one write of 32'h0, back to IDLE.
- Ch0 samples 100..107 -> avg=103 (828>>3), avg_valid[0]=1. Then rd_req rd_ch=0 -> rd_ack next cycle, rd_data=103.
- thresh_hi=2000, thresh_lo=1800; ch1 averages 2100, 1900, 1700 -> alarm[1] = 1, 1, 0 respectively, each one cycle after the avg update.
- s_channel=9 (NUM_CH=4, CH_BASE=0) or s_valid while IDLE -> drop_pulse=1 next cycle; no accumulator change.
- 5 samples to ch2, enable=0 then 1, then 8 samples of 50 -> avg=50 (partial sum discarded). rst asserted mid-RUN -> all outputs 0 immediately.
- TEMP_MINMAX_EN: ch3 averages 300, 100, 200 -> rd_min=100, rd_max=300. Without macro -> rd_min=0, rd_max=12'hFFF.
